// File: rtl/imem_loader.sv
// Byte-stream loader and owner of the instruction memory; holds the core in reset while loading.
// Optional running byte checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int DEPTH_BYTES = 128,
   parameter int ADDR_W      = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   input  logic              s_last,
   output logic              s_ready,
   input  logic [ADDR_W-1:0] r_addr_imem,
   output logic [31:0]       r_data_imem,
   output logic              busy,
   output logic              done,
   output logic              err_overflow,
   output logic              core_rst_n,
   output logic [ADDR_W:0]   byte_count,
   output logic [7:0]        csum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE,
      S_ERR
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_core_rst_n;
   logic [7:0]        r_mem [DEPTH_BYTES];
   logic              w_acc;
   logic              w_start;
   logic              w_at_end;
   logic [ADDR_W-1:0] w_a1;
   logic [ADDR_W-1:0] w_a2;
   logic [ADDR_W-1:0] w_a3;

   assign w_acc    = (r_state == S_LOAD) && s_valid;
   assign w_start  = start && (r_state != S_LOAD);
   assign w_at_end = (r_wr_ptr == ADDR_W'(DEPTH_BYTES - 1));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_LOAD: begin
            if (w_acc) begin
               if (s_last)
                  w_next = S_DONE;
               else if (w_at_end)
                  w_next = S_ERR;
            end
         end
         default: begin
            if (start)
               w_next = S_LOAD;
         end
      endcase
   end

   // core reset follows the next state so it lifts together with DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_core_rst_n <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_core_rst_n <= (w_next == S_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_start) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_acc) begin
         r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         r_count  <= r_count + (ADDR_W + 1)'(1);
      end
   end

   // storage is deliberately not reset so a partial image survives rst_n
   always_ff @(posedge clk) begin
      if (w_acc)
         r_mem[r_wr_ptr] <= s_data;
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] r_csum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_csum <= 8'h00;
      else if (w_start)
         r_csum <= 8'h00;
      else if (w_acc)
         r_csum <= r_csum + s_data;
   end

   assign csum = r_csum;
`else
   assign csum = 8'h00;
`endif

   assign w_a1 = r_addr_imem + ADDR_W'(1);
   assign w_a2 = r_addr_imem + ADDR_W'(2);
   assign w_a3 = r_addr_imem + ADDR_W'(3);

   assign r_data_imem = {r_mem[w_a3], r_mem[w_a2],
                         r_mem[w_a1], r_mem[r_addr_imem]};

   assign s_ready      = (r_state == S_LOAD);
   assign busy         = (r_state == S_LOAD);
   assign done         = (r_state == S_DONE);
   assign err_overflow = (r_state == S_ERR);
   assign core_rst_n   = r_core_rst_n;
   assign byte_count   = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader against a byte-array reference model.
// Honours IMEM_LOADER_CHECKSUM_EN for the expected checksum.
module tb_imem_loader;

   localparam int N = 128;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic        s_ready;
   logic [6:0]  r_addr_imem;
   logic [31:0] r_data_imem;
   logic        busy;
   logic        done;
   logic        err_overflow;
   logic        core_rst_n;
   logic [7:0]  byte_count;
   logic [7:0]  csum;

   imem_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_ready      (s_ready),
      .r_addr_imem  (r_addr_imem),
      .r_data_imem  (r_data_imem),
      .busy         (busy),
      .done         (done),
      .err_overflow (err_overflow),
      .core_rst_n   (core_rst_n),
      .byte_count   (byte_count),
      .csum         (csum)
   );

   always #5 clk = ~clk;

   typedef enum int {M_IDLE, M_LOAD, M_DONE, M_ERR} mstate_t;

   logic [7:0] mem_m [N];
   bit         known [N];
   mstate_t    ms;
   int         cnt;
   int         wp;
   logic [7:0] sum;
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
      return sum;
`else
      return 8'h00;
`endif
   endfunction

   function automatic logic [31:0] ref_word(input int a);
      return {mem_m[(a + 3) % N], mem_m[(a + 2) % N],
              mem_m[(a + 1) % N], mem_m[a % N]};
   endfunction

   function automatic bit word_known(input int a);
      return known[a % N] && known[(a + 1) % N] &&
             known[(a + 2) % N] && known[(a + 3) % N];
   endfunction

   task automatic check_status(input string tag);
      chk({tag, ".busy"},  32'(busy),         32'(ms == M_LOAD));
      chk({tag, ".rdy"},   32'(s_ready),      32'(ms == M_LOAD));
      chk({tag, ".done"},  32'(done),         32'(ms == M_DONE));
      chk({tag, ".err"},   32'(err_overflow), 32'(ms == M_ERR));
      chk({tag, ".crst"},  32'(core_rst_n),   32'(ms == M_DONE));
      chk({tag, ".cnt"},   32'(byte_count),   32'(cnt));
      chk({tag, ".csum"},  32'(csum),         32'(exp_csum()));
   endtask

   task automatic do_start(input string tag);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (ms != M_LOAD) begin
         ms  = M_LOAD;
         cnt = 0;
         wp  = 0;
         sum = 8'h00;
      end
      check_status(tag);
   endtask

   // presents one byte for one clock; the model decides whether it lands
   task automatic send_byte(input string tag, input logic [7:0] d,
                            input logic l);
      s_valid     = 1'b1;
      s_data      = d;
      s_last      = l;
      r_addr_imem = 7'(wp);
      #1;
      if (known[wp])
         chk({tag, ".old"}, 32'(r_data_imem[7:0]), 32'(mem_m[wp]));
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (ms == M_LOAD) begin
         mem_m[wp] = d;
         known[wp] = 1'b1;
         wp        = (wp + 1) % N;
         cnt++;
         sum = sum + d;
         if (l)
            ms = M_DONE;
         else if (cnt == N)
            ms = M_ERR;
      end
      check_status(tag);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd_check(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         int a;
         a = $urandom_range(0, N - 1);
         if (word_known(a)) begin
            r_addr_imem = 7'(a);
            #1;
            chk(tag, r_data_imem, ref_word(a));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rd_at(input string tag, input int a,
                        input logic [31:0] exp);
      r_addr_imem = 7'(a);
      #1;
      chk(tag, r_data_imem, exp);
   endtask

   initial begin
      logic [7:0] v4 [4];
      logic [7:0] b;
      rst_n       = 1'b0;
      start       = 1'b0;
      s_valid     = 1'b0;
      s_data      = 8'h00;
      s_last      = 1'b0;
      r_addr_imem = 7'd0;
      ms  = M_IDLE;
      cnt = 0;
      wp  = 0;
      sum = 8'h00;
      for (int i = 0; i < N; i++)
         known[i] = 1'b0;
      idle_cycles(2);
      check_status("rst");
      rst_n = 1'b1;
      idle_cycles(1);

      // short program: one addi word
      do_start("t1.start");
      v4[0] = 8'h13; v4[1] = 8'h00; v4[2] = 8'h00; v4[3] = 8'h00;
      for (int i = 0; i < 4; i++)
         send_byte("t1", v4[i], i == 3);
      rd_at("t1.word", 0, 32'h00000013);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("t1.csum13", 32'(csum), 32'h13);
`endif

      // full legal image
      do_start("t2.start");
      for (int i = 0; i < N; i++)
         send_byte("t2", 8'(i), i == N - 1);
      rd_at("t2.wrap", 126, 32'h01007F7E);
      rd_at("t2.a5",   5,   32'h08070605);
      rd_check("t2.rd", 16);

      // overflow with random bytes, then a rejected extra byte
      do_start("t3.start");
      for (int i = 0; i < N; i++)
         send_byte("t3", 8'($urandom), 1'b0);
      for (int i = 0; i < 3; i++)
         send_byte("t3.extra", 8'($urandom), 1'b0);
      rd_check("t3.rd", 16);
      do_start("t3.restart");

      // gapped stream with an ignored start in the middle
      v4[0] = 8'h11; v4[1] = 8'h22; v4[2] = 8'h33; v4[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         idle_cycles($urandom_range(0, 3));
         check_status("t4.gap");
         if (i == 2)
            do_start("t4.midstart");
         send_byte("t4", v4[i], i == 3);
      end
      rd_at("t4.word", 0, 32'h44332211);
      rd_check("t4.rd", 16);

      // asynchronous reset part-way through a load
      do_start("t5.start");
      for (int i = 0; i < 2; i++)
         send_byte("t5", 8'($urandom), 1'b0);
      rst_n = 1'b0;
      #1;
      ms  = M_IDLE;
      cnt = 0;
      wp  = 0;
      sum = 8'h00;
      check_status("t5.arst");
      rd_at("t5.keep", 0, ref_word(0));
      idle_cycles(1);
      rst_n = 1'b1;
      idle_cycles(1);
      check_status("t5.idle");
      send_byte("t5.ignored", 8'h5A, 1'b1);

      // random image, then a one-byte reload over it
      do_start("t6.start");
      for (int i = 0; i < 8; i++)
         send_byte("t6", 8'($urandom), i == 7);
      rd_check("t6.rd", 8);
      do_start("t6.restart");
      send_byte("t6.aa", 8'hAA, 1'b1);
      rd_at("t6.word", 0, ref_word(0));
      chk("t6.lo", 32'(r_data_imem[7:0]), 32'hAA);

      // random loads of random length with random gaps
      for (int k = 0; k < 6; k++) begin
         int len;
         len = $urandom_range(1, 40);
         do_start("rnd.start");
         for (int i = 0; i < len; i++) begin
            idle_cycles($urandom_range(0, 2));
            b = 8'($urandom);
            send_byte("rnd", b, i == len - 1);
         end
         rd_check("rnd.rd", 8);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
